pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have these ports: clk  in  1  single clock for all state.
REQ-002 rst  in  1  asynchronous reset, active-low; all registers clear on rst low, independent of clk.
REQ-003 stallreq_if  in  1  IF stage instruction fetch outstanding.
REQ-004 stallreq_id  in  1  ID hazard, load-use or operand not ready.
REQ-005 stallreq_ex  in  1  EX multi-cycle operation busy.
REQ-006 stallreq_mem  in  1  MEM data access outstanding.
REQ-007 id_branch_flag  in  1  ID resolved a taken branch or jump this cycle.
REQ-008 id_branch_target  in  32  target address of that branch.
REQ-009 stall  out  6  per-stage hold vector: [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb; Stop=1, NoStop=0.
REQ-010 pc_redirect  out  1  PC SHALL load redirect_addr this cycle.
REQ-011 redirect_addr  out  32  redirect target.
REQ-012 flush_if  out  1  IF/ID SHALL discard its incoming instruction and load a bubble.
REQ-013 stall_cycles  out  32  count of cycles with stall[0]=Stop.
REQ-014 hang_err  out  1  sticky watchdog error.

Function
REQ-015 stall SHALL be combinational from the current requests, with the highest requesting stage taking priority: mem -> 011111, else ex -> 001111, else id -> 000111, else if -> 000011, else 000000.
REQ-016 stall[5] SHALL always be NoStop.
REQ-017 The downstream pipeline registers insert a bubble where stall[i]=Stop and stall[i+1]=NoStop; this block SHALL NOT drive separate bubble signals.
REQ-018 The FSM SHALL have two states: RUN (reset state) and HOLD_BR.
REQ-019 id_branch_flag SHALL be accepted only in RUN and only when stall[2]=NoStop; otherwise it is ignored, because ID re-presents the branch.
REQ-020 Accepted branch with stallreq_if=0: in the same cycle pc_redirect=1, redirect_addr=id_branch_target, flush_if=1; the FSM stays in RUN.
REQ-021 Accepted branch with stallreq_if=1: the block SHALL register id_branch_target into pend_addr and enter HOLD_BR next cycle; pc_redirect=0 in the capture cycle.
REQ-022 In HOLD_BR with stallreq_if=1: pc_redirect=0, flush_if=0; the FSM stays in HOLD_BR.
REQ-023 In HOLD_BR with stallreq_if=0: pc_redirect=1, redirect_addr=pend_addr, flush_if=1; the FSM returns to RUN next cycle.
REQ-024 In HOLD_BR, id_branch_flag SHALL be ignored.
REQ-025 When pc_redirect=0, redirect_addr SHALL be 0 and flush_if SHALL be 0.
REQ-026 stall_cycles SHALL increment by 1 on each clk edge where stall[0]=Stop, and SHALL saturate at 0xFFFFFFFF with no wrap.
REQ-027 An 8-bit watchdog counter SHALL increment on each edge where any stallreq_* is 1, and clear on each edge where all are 0.
REQ-028 When the watchdog counter reaches 255, hang_err SHALL set on that edge and stay 1 until reset; the counter SHALL saturate at 255.
REQ-029 All registered outputs SHALL update one cycle after the causing edge; stall, pc_redirect, redirect_addr and flush_if SHALL have zero latency.

Reset
REQ-030 On rst=0: state=RUN, pend_addr=0, stall_cycles=0, watchdog=0, hang_err=0.
REQ-031 While rst=0, the combinational outputs SHALL be: stall=000000, pc_redirect=0, redirect_addr=0, flush_if=0.
REQ-032 Reset asserted in HOLD_BR SHALL drop the pending redirect with no redirect issued after release.

Structure
REQ-033 Stop/NoStop, the stall-vector width, the 32-bit address bus width and the FSM state encoding SHALL live in the shared defines package.
REQ-034 The saturating counters SHALL be one sub-module, sat_counter, parameterised by width, used for both stall_cycles and the watchdog.

Verification
REQ-035 stallreq_ex=1 with all other requests 0 -> stall=001111; after 3 cycles, stall_cycles=3.
REQ-036 stallreq_mem=1 and stallreq_id=1 together -> stall=011111 (mem priority).
REQ-037 id_branch_flag=1, target 0x00001000, stallreq_if=0 -> same-cycle pc_redirect=1, redirect_addr=0x00001000, flush_if=1.
REQ-038 Branch to 0x00002040 with stallreq_if=1 held 4 cycles -> HOLD_BR; redirect to 0x00002040 with flush_if=1 in the cycle stallreq_if falls, then RUN.
REQ-039 id_branch_flag=1 together with stallreq_mem=1 -> no redirect, and the FSM stays in RUN.
REQ-040 stallreq_id held 255 cycles -> hang_err=1, still 1 after the request drops; rst low mid-HOLD_BR -> all registers 0 and no later redirect.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control block: stall encoding,
// bus widths, FSM state encoding and the stall-vector priority helper.
package pipeline_ctrl_pkg;

   // Stall-vector bit polarity
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Widths
   localparam int STALL_W     = 6;
   localparam int ADDR_W      = 32;
   localparam int STALL_CNT_W = 32;
   localparam int WDOG_W      = 8;

   // Stall-vector bit positions, pc is the oldest point of the pipe
   localparam int IDX_PC  = 0;
   localparam int IDX_IF  = 1;
   localparam int IDX_ID  = 2;
   localparam int IDX_EX  = 3;
   localparam int IDX_MEM = 4;
   localparam int IDX_WB  = 5;

   // Hold patterns: a requesting stage freezes itself and everything upstream
   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

   // The watchdog trips on the edge that takes it from this value to all-ones
   localparam logic [WDOG_W-1:0] WDOG_TRIP = 8'd254;

   // Branch redirect FSM: RUN accepts branches, HOLD_BR parks one while IF is busy
   typedef enum logic {
      RUN     = 1'b0,
      HOLD_BR = 1'b1
   } state_t;

   // Highest requesting stage wins; wb is never held
   function automatic logic [STALL_W-1:0] stall_vector(
      input logic req_if,
      input logic req_id,
      input logic req_ex,
      input logic req_mem
   );
      logic [STALL_W-1:0] vec;
      vec = STALL_NONE;
      if (req_mem) begin
         vec = STALL_MEM;
      end else if (req_ex) begin
         vec = STALL_EX;
      end else if (req_id) begin
         vec = STALL_ID;
      end else if (req_if) begin
         vec = STALL_IF;
      end
      return vec;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. Sticks at all-ones instead
// of wrapping, so long-running statistics and the watchdog never roll over.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   // Count up on inc, clear wins over inc, hold once saturated
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_VAL)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: turns per-stage stall requests into a
// prioritised hold vector, steers taken branches from ID onto the PC
// (parking them while instruction fetch is still busy), counts stalled
// cycles and raises a sticky error if some stage never stops requesting.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stallreq_if,
   input  logic                   stallreq_id,
   input  logic                   stallreq_ex,
   input  logic                   stallreq_mem,
   input  logic                   id_branch_flag,
   input  logic [ADDR_W-1:0]      id_branch_target,
   output logic [STALL_W-1:0]     stall,
   output logic                   pc_redirect,
   output logic [ADDR_W-1:0]      redirect_addr,
   output logic                   flush_if,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic                   hang_err
);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] pend_addr;
   logic              any_req;
   logic              branch_ok;
   logic              capture_br;
   logic [WDOG_W-1:0] wdog_count;
   logic              wdog_inc;
   logic              wdog_clr;
   logic              hang_set;

   // Hold vector straight from the requests; forced quiet while in reset
   always_comb begin
      stall = STALL_NONE;
      if (rst) begin
         stall = stall_vector(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
      end
   end

   // A branch is taken only in RUN with ID free to move; a held ID re-presents it later
   always_comb begin
      any_req    = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
      branch_ok  = rst && (state == RUN) && id_branch_flag && (stall[IDX_ID] == NO_STOP);
      capture_br = branch_ok && stallreq_if;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // FSM next state: park the branch while fetch is busy, release when fetch frees up
   always_comb begin
      next_state = state;
      case (state)
         RUN: begin
            if (capture_br) begin
               next_state = HOLD_BR;
            end
         end
         HOLD_BR: begin
            if (!stallreq_if) begin
               next_state = RUN;
            end
         end
         default: begin
            next_state = RUN;
         end
      endcase
   end

   // FSM outputs: redirect and flush together, address only driven while redirecting
   always_comb begin
      pc_redirect   = 1'b0;
      redirect_addr = '0;
      flush_if      = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               if (branch_ok && !stallreq_if) begin
                  pc_redirect   = 1'b1;
                  redirect_addr = id_branch_target;
                  flush_if      = 1'b1;
               end
            end
            HOLD_BR: begin
               if (!stallreq_if) begin
                  pc_redirect   = 1'b1;
                  redirect_addr = pend_addr;
                  flush_if      = 1'b1;
               end
            end
            default: begin
               pc_redirect   = 1'b0;
            end
         endcase
      end
   end

   // Remember the branch target while the redirect is parked
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_addr <= '0;
      end else if (capture_br) begin
         pend_addr <= id_branch_target;
      end
   end

   sat_counter #(
      .WIDTH(STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall[IDX_PC] == STOP),
      .clr   (1'b0),
      .count (stall_cycles)
   );

   // Watchdog runs while anyone is requesting and restarts as soon as nobody is
   always_comb begin
      wdog_inc = any_req;
      wdog_clr = ~any_req;
      hang_set = wdog_inc && (wdog_count >= WDOG_TRIP);
   end

   sat_counter #(
      .WIDTH(WDOG_W)
   ) u_wdog_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wdog_inc),
      .clr   (wdog_clr),
      .count (wdog_count)
   );

   // Sticky hang flag, set on the edge the watchdog reaches full scale
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hang_err <= 1'b0;
      end else if (hang_set) begin
         hang_err <= 1'b1;
      end
   end

endmodule
